// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle processor control FSM: sequences fetch, decode, execute, memory
// and write-back, and drives the datapath strobes for each step.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       cond_true,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_src,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pcsel,
    output logic       regwrite,
    output logic       alusrc,
    output logic       memtoreg,
    output logic       pcread,
    output logic [3:0] aluop,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_B   = 4'b1010;
    localparam logic [3:0] OP_PCS = 4'b1011;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;

    logic       isAlu, isLw, isSw, isBr, isPcs;
    logic [3:0] decAluop;
    logic       decAlusrc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Decoded controls come only from the latched opcode, never the live IR.
    always_comb begin
        isAlu     = ~op_q[3];
        isLw      = (op_q == OP_LW);
        isSw      = (op_q == OP_SW);
        isBr      = (op_q == OP_B);
        isPcs     = (op_q == OP_PCS);
        decAluop  = isAlu ? op_q : 4'b0000;
        decAlusrc = isAlu ? op_q[2] : (isLw | isSw);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        state    = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_src  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pcsel    = 1'b0;
        regwrite = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        pcread   = 1'b0;
        aluop    = 4'b0000;
        halted   = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                    op_d    = opcode;
                end
            end
            S_EXEC: begin
                aluop  = decAluop;
                alusrc = decAlusrc;
                if (isAlu || isPcs) begin
                    state_d = S_WB;
                end else if (isLw || isSw) begin
                    state_d = S_MEM;
                end else if (isBr) begin
                    pc_we   = 1'b1;
                    pcsel   = cond_true;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_src = 1'b1;
                mem_we  = isSw;
                aluop   = decAluop;
                alusrc  = decAlusrc;
                if (mem_ready) begin
                    state_d = isLw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                memtoreg = isLw;
                pcread   = isPcs;
                aluop    = decAluop;
                alusrc   = decAlusrc;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset silences every output immediately, even though the state
        // register already sits in FETCH, so no request leaks out during reset.
        if (rst) begin
            state    = 3'd0;
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            mem_src  = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pcsel    = 1'b0;
            regwrite = 1'b0;
            alusrc   = 1'b0;
            memtoreg = 1'b0;
            pcread   = 1'b0;
            aluop    = 4'b0000;
            halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: table of instructions checked
// cycle by cycle through an expected-output queue, plus halt and reset cases.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       cond_true;
    logic       mem_ready;
    logic [2:0] state;
    logic       mem_req, mem_we, mem_src, ir_we, pc_we, pcsel;
    logic       regwrite, alusrc, memtoreg, pcread, halted;
    logic [3:0] aluop;

    multi_cycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .cond_true (cond_true),
        .mem_ready (mem_ready),
        .state     (state),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_src   (mem_src),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pcsel     (pcsel),
        .regwrite  (regwrite),
        .alusrc    (alusrc),
        .memtoreg  (memtoreg),
        .pcread    (pcread),
        .aluop     (aluop),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       src;
        logic       irWe;
        logic       pcWe;
        logic       pcsel;
        logic       regwrite;
        logic       alusrc;
        logic       memtoreg;
        logic       pcread;
        logic [3:0] aluop;
        logic       halted;
    } out_t;

    typedef struct {
        logic [3:0] opcode;
        logic       cond;
        int         fetchWait;
        int         memWait;
        logic [3:0] aluop;
        logic       alusrc;
        logic       isBranch;
        logic       hasMem;
        logic       memWe;
        logic       hasWb;
        logic       memtoreg;
        logic       pcread;
    } vec_t;

    out_t expQ[$];
    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;

    function automatic out_t blank(input logic [2:0] st);
        out_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    function automatic out_t sampleDut();
        out_t o;
        o.st       = state;
        o.req      = mem_req;
        o.we       = mem_we;
        o.src      = mem_src;
        o.irWe     = ir_we;
        o.pcWe     = pc_we;
        o.pcsel    = pcsel;
        o.regwrite = regwrite;
        o.alusrc   = alusrc;
        o.memtoreg = memtoreg;
        o.pcread   = pcread;
        o.aluop    = aluop;
        o.halted   = halted;
        return o;
    endfunction

    // Inputs change on the falling edge; the expected view of that cycle is queued.
    task automatic applyStimulus(input logic [3:0] op, input logic cond,
                                 input logic rdy, input out_t exp);
        @(negedge clk);
        opcode    = op;
        cond_true = cond;
        mem_ready = rdy;
        expQ.push_back(exp);
    endtask

    task automatic checkOutput(input string name);
        out_t exp;
        out_t act;
        #1;
        exp = expQ.pop_front();
        act = sampleDut();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] op, input logic cond, input logic rdy,
                        input out_t exp, input string name);
        applyStimulus(op, cond, rdy, exp);
        checkOutput(name);
    endtask

    // Walks one instruction from FETCH back to FETCH; the live opcode is
    // scrambled outside DECODE so only the latched copy can steer outputs.
    task automatic runInstr(input vec_t v, input int idx);
        out_t       e;
        logic [3:0] junk;
        junk = ~v.opcode;
        for (int i = 0; i < v.fetchWait; i++) begin
            e = blank(3'd0);
            e.req = 1'b1;
            step(junk, 1'b0, 1'b0, e, $sformatf("v%0d fetch-wait", idx));
        end
        e = blank(3'd0);
        e.req  = 1'b1;
        e.irWe = 1'b1;
        e.pcWe = 1'b1;
        step(junk, 1'b0, 1'b1, e, $sformatf("v%0d fetch-ready", idx));
        step(v.opcode, 1'b1, 1'b1, blank(3'd1), $sformatf("v%0d decode", idx));
        e = blank(3'd2);
        e.aluop  = v.aluop;
        e.alusrc = v.alusrc;
        if (v.isBranch) begin
            e.pcWe  = 1'b1;
            e.pcsel = v.cond;
        end
        step(junk, v.cond, 1'b1, e, $sformatf("v%0d exec", idx));
        if (v.hasMem) begin
            for (int i = 0; i <= v.memWait; i++) begin
                e = blank(3'd3);
                e.req    = 1'b1;
                e.src    = 1'b1;
                e.we     = v.memWe;
                e.aluop  = v.aluop;
                e.alusrc = v.alusrc;
                step(junk, ~v.cond, (i == v.memWait), e, $sformatf("v%0d mem%0d", idx, i));
            end
        end
        if (v.hasWb) begin
            e = blank(3'd4);
            e.regwrite = 1'b1;
            e.memtoreg = v.memtoreg;
            e.pcread   = v.pcread;
            e.aluop    = v.aluop;
            e.alusrc   = v.alusrc;
            step(junk, 1'b1, 1'b1, e, $sformatf("v%0d wb", idx));
        end
    endtask

    // Releases reset between edges and checks the very first post-reset cycle.
    task automatic releaseReset(input string name);
        out_t e;
        mem_ready = 1'b0;
        rst       = 1'b0;
        e = blank(3'd0);
        e.req = 1'b1;
        expQ.push_back(e);
        checkOutput(name);
    endtask

    initial begin
        out_t e;

        // opcode cond fw mw aluop src br mem we wb m2r pcr
        vecs[0]  = '{4'b0100, 1'b0, 0, 0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'b0011, 1'b0, 1, 0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'b0000, 1'b1, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'b0111, 1'b0, 0, 0, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 1'b0, 0, 2, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{4'b1000, 1'b1, 1, 0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'b1001, 1'b0, 0, 0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b1001, 1'b1, 2, 1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1010, 1'b1, 0, 0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b1010, 1'b0, 0, 0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b1011, 1'b0, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{4'b1100, 1'b1, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'b1101, 1'b0, 1, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'b1110, 1'b1, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        opcode    = 4'b0000;
        cond_true = 1'b1;
        mem_ready = 1'b1;

        // Outputs stay silent throughout reset even with mem_ready high.
        step(4'b0100, 1'b1, 1'b1, blank(3'd0), "reset-0");
        step(4'b1111, 1'b1, 1'b1, blank(3'd0), "reset-1");
        releaseReset("reset-release");

        for (int i = 0; i < 14; i++) begin
            runInstr(vecs[i], i);
        end

        // LW interrupted by reset while MEM is still waiting for memory.
        e = blank(3'd0);
        e.req = 1'b1; e.irWe = 1'b1; e.pcWe = 1'b1;
        step(4'b0111, 1'b0, 1'b1, e, "abort fetch");
        step(4'b1000, 1'b0, 1'b0, blank(3'd1), "abort decode");
        e = blank(3'd2);
        e.alusrc = 1'b1;
        step(4'b0111, 1'b0, 1'b0, e, "abort exec");
        e = blank(3'd3);
        e.req = 1'b1; e.src = 1'b1; e.alusrc = 1'b1;
        step(4'b0111, 1'b0, 1'b0, e, "abort mem-wait");
        #2;
        rst = 1'b1;
        expQ.push_back(blank(3'd0));
        checkOutput("abort async-clear");
        step(4'b0111, 1'b0, 1'b1, blank(3'd0), "abort reset-held");
        releaseReset("abort first-fetch");
        runInstr(vecs[0], 100);

        // HLT is sticky regardless of mem_ready activity.
        e = blank(3'd0);
        e.req = 1'b1; e.irWe = 1'b1; e.pcWe = 1'b1;
        step(4'b0000, 1'b0, 1'b1, e, "hlt fetch");
        step(4'b1111, 1'b0, 1'b1, blank(3'd1), "hlt decode");
        for (int i = 0; i < 20; i++) begin
            e = blank(3'd5);
            e.halted = 1'b1;
            step(4'(i), (i % 3) == 0, (i % 2) == 1, e, $sformatf("halt%0d", i));
        end
        #2;
        rst = 1'b1;
        expQ.push_back(blank(3'd0));
        checkOutput("halt async-clear");
        step(4'b0000, 1'b0, 1'b1, blank(3'd0), "halt reset-held");
        releaseReset("halt first-fetch");
        runInstr(vecs[4], 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock, rising-edge active.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port opcode, input, 4, instruction opcode from the external IR, sampled only in DECODE.
REQ-004 SHALL have port cond_true, input, 1, branch condition from the flag unit, sampled only in EXEC.
REQ-005 SHALL have port mem_ready, input, 1, memory accept/complete; ignored while mem_req=0.
REQ-006 SHALL have port state, output, 3, current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-007 SHALL have ports mem_req, mem_we and mem_src, output, 1 each: request, write enable, and address select (0=PC, 1=ALU result).
REQ-008 SHALL have ports ir_we and pc_we, output, 1 each: IR load strobe and PC load strobe.
REQ-009 SHALL have port pcsel, output, 1: PC source select (0=PC+2, 1=branch target).
REQ-010 SHALL have ports regwrite, alusrc, memtoreg and pcread, output, 1 each: datapath controls.
REQ-011 SHALL have port aluop, output, 4: ALU operation select.
REQ-012 SHALL have port halted, output, 1: high in HALT.

Function
REQ-013 SHALL latch opcode into internal op_q on the DECODE->EXEC edge; all decoded controls SHALL derive from op_q, never from the live opcode.
REQ-014 SHALL decode op_q as follows:
- 0xxx: ALU op; aluop=op_q; alusrc=op_q[2].
- 1000: LW; alusrc=1; aluop=0000.
- 1001: SW; alusrc=1; aluop=0000.
- 1010: B (branch).
- 1011: PCS.
- 1111: HLT.
- 1100-1110: NOP.
REQ-015 SHALL drive aluop and alusrc per REQ-014 in EXEC, MEM and WB; both SHALL be 0 in other states.
REQ-016 FETCH SHALL drive mem_req=1, mem_src=0, mem_we=0, and hold these until mem_ready=1 is sampled.
- In the ready cycle: ir_we=1, pc_we=1, pcsel=0.
- Next state: DECODE.
REQ-017 DECODE SHALL last exactly one cycle; next state is HALT if opcode=1111, else EXEC.
REQ-018 EXEC SHALL last one cycle; next state by op_q:
- ALU op or PCS: WB.
- LW or SW: MEM.
- B: pc_we=1, pcsel=cond_true; next FETCH.
- NOP: FETCH.
REQ-019 MEM SHALL drive mem_req=1, mem_src=1, mem_we=(op_q==SW), and hold these until mem_ready=1 is sampled.
- On ready: LW goes to WB; SW goes to FETCH.
REQ-020 WB SHALL last one cycle, regwrite=1, memtoreg=(op_q==LW), pcread=(op_q==PCS); next state FETCH.
REQ-021 HALT SHALL be sticky until rst; halted=1, all strobes 0, mem_req=0.
REQ-022 regwrite, pc_we, ir_we and mem_we SHALL each pulse for exactly one cycle per instruction at most; no strobe SHALL be asserted outside its state.
REQ-023 With zero-wait memory, latency SHALL be:
- ALU op / PCS: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- B / NOP: 3 cycles.
- Each mem_ready wait cycle adds 1 cycle.
REQ-024 mem_ready=1 in any state other than FETCH or MEM SHALL have no effect.
REQ-025 Outputs SHALL be functions of state and op_q, plus mem_ready for the FETCH/MEM ready-cycle strobes, plus cond_true for pcsel in EXEC; no other combinational input-to-output paths SHALL exist.

Reset
REQ-026 While rst=1, state SHALL be FETCH, op_q SHALL be 0000, and every output SHALL be 0, including mem_req and halted.
REQ-027 Reset asserted mid-instruction, including during a pending MEM handshake, SHALL abort it immediately with no strobe emitted; the first mem_req=1 SHALL appear in the first cycle after rst deasserts.

Verification
REQ-028 ALU op: opcode=0100, mem_ready=1 always.
- Expected state sequence: 0,1,2,4,0.
- In EXEC/WB: alusrc=1, aluop=0100.
- regwrite=1 only in the WB cycle.
REQ-029 LW with data-memory wait: opcode=1000, mem_ready low for 2 MEM cycles.
- MEM is held for 3 cycles with mem_req=1, mem_src=1, mem_we=0.
- Then WB with regwrite=1, memtoreg=1, alusrc=1, aluop=0000.
REQ-030 Branch: opcode=1010.
- cond_true=1: EXEC shows pc_we=1, pcsel=1.
- cond_true=0: EXEC shows pc_we=1, pcsel=0.
- Both cases: next state 0, regwrite never 1.
REQ-031 SW: opcode=1001, ready on the first MEM cycle.
- MEM shows mem_we=1; next state FETCH.
- No WB state and no regwrite pulse.
REQ-032 HLT: opcode=1111.
- Sequence 0,1,5; halted=1 persists for 20 cycles while mem_ready toggles.
- Asserting rst returns state=0, halted=0.
REQ-033 Async reset: assert rst mid-cycle while in MEM with mem_req=1.
- Outputs go to 0 before the next clock edge.
- After release: state=0 and mem_req=1 in the first cycle.
